// File: rtl/orv64_typedef_pkg.sv
// Shared ORV64 bus payload types plus the L2 port arbiter additions.
package orv64_typedef_pkg;

  localparam int unsigned ORV64_PADDR_W = 40;
  localparam int unsigned ORV64_XLEN    = 64;
  localparam int unsigned ORV64_MASK_W  = ORV64_XLEN / 8;

  // Upstream request toward the memory hierarchy.
  typedef struct packed {
    logic [ORV64_PADDR_W-1:0] addr;
    logic                     we;
    logic [ORV64_XLEN-1:0]    wdata;
    logic [ORV64_MASK_W-1:0]  mask;
  } cpu_req_t;

  // Response returned for each request.
  typedef struct packed {
    logic [ORV64_XLEN-1:0] rdata;
    logic                  err;
  } cpu_resp_t;

  localparam int unsigned ORV64_L2_ARB_PORT_CNT_DEFAULT    = 8;
  localparam int unsigned ORV64_L2_ARB_OUTSTANDING_DEFAULT = 4;
  localparam int unsigned ORV64_ARB_PORT_W = $clog2(ORV64_L2_ARB_PORT_CNT_DEFAULT);

  typedef logic [ORV64_ARB_PORT_W-1:0] orv64_arb_port_idx_t;

  // (base + off) mod modulus, valid for base < modulus and off < modulus.
  function automatic int unsigned orv64_arb_wrap_add(int unsigned base, int unsigned off,
                                                     int unsigned modulus);
    int unsigned sum;
    sum = base + off;
    if (sum >= modulus) begin
      sum = sum - modulus;
    end
    return sum;
  endfunction

endpackage

// File: rtl/orv64_arb_order_fifo.sv
// In-order FIFO of port indices: remembers which port owns each in-flight L2 transaction.
module orv64_arb_order_fifo
  import orv64_typedef_pkg::*;
#(
  parameter int unsigned DEPTH  = ORV64_L2_ARB_OUTSTANDING_DEFAULT,
  parameter int unsigned DATA_W = ORV64_ARB_PORT_W,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[ADDR_W-1:0]];

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/orv64_l2_port_arb.sv
// Round-robin arbiter from PORT_CNT cpu ports onto the single L2 port, with in-order response routing.
module orv64_l2_port_arb
  import orv64_typedef_pkg::*;
#(
  parameter  int unsigned PORT_CNT    = ORV64_L2_ARB_PORT_CNT_DEFAULT,
  parameter  int unsigned OUTSTANDING = ORV64_L2_ARB_OUTSTANDING_DEFAULT,
  localparam int unsigned PORT_W      = $clog2(PORT_CNT),
  localparam int unsigned CNT_W       = $clog2(OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORT_CNT-1:0]       cpu_req_valid,
  output logic [PORT_CNT-1:0]       cpu_req_ready,
  input  cpu_req_t [PORT_CNT-1:0]   cpu_req,
  output logic [PORT_CNT-1:0]       cpu_resp_valid,
  input  logic [PORT_CNT-1:0]       cpu_resp_ready,
  output cpu_resp_t [PORT_CNT-1:0]  cpu_resp,
  output logic                      l2_req_valid,
  input  logic                      l2_req_ready,
  output cpu_req_t                  l2_req,
  input  logic                      l2_resp_valid,
  output logic                      l2_resp_ready,
  input  cpu_resp_t                 l2_resp,
  output logic [CNT_W-1:0]          inflight_cnt,
  output logic                      err_orphan_resp
);

  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] grant_idx;
  logic              grant_found;
  logic [PORT_W-1:0] head_idx;
  logic              fifo_full;
  logic              fifo_empty;
  logic              slot_free;
  logic              credit_ok;
  logic              accept;
  logic              resp_pop;
  logic              orphan_seen;

  // FIFO depth equals OUTSTANDING, so "not full" is exactly inflight_cnt < OUTSTANDING.
  assign slot_free   = !l2_req_valid || l2_req_ready;
  assign credit_ok   = !fifo_full;
  assign accept      = rst_n && slot_free && credit_ok && grant_found;
  assign resp_pop    = l2_resp_valid && l2_resp_ready && !fifo_empty;
  assign orphan_seen = l2_resp_valid && fifo_empty;

  // Grant the first valid port at or after rr_ptr, wrapping modulo PORT_CNT.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned off = 0; off < PORT_CNT; off++) begin
      if (!grant_found &&
          cpu_req_valid[PORT_W'(orv64_arb_wrap_add(32'(rr_ptr), off, PORT_CNT))]) begin
        grant_idx   = PORT_W'(orv64_arb_wrap_add(32'(rr_ptr), off, PORT_CNT));
        grant_found = 1'b1;
      end
    end
  end

  // One-hot ready to the granted port only.
  always_comb begin
    cpu_req_ready            = '0;
    cpu_req_ready[grant_idx] = accept;
  end

  // Route the L2 response to the port at the FIFO head; orphans are swallowed.
  always_comb begin
    cpu_resp_valid = '0;
    l2_resp_ready  = 1'b0;
    if (rst_n) begin
      if (fifo_empty) begin
        l2_resp_ready = 1'b1;
      end else begin
        cpu_resp_valid[head_idx] = l2_resp_valid;
        l2_resp_ready            = cpu_resp_ready[head_idx];
      end
    end
  end

  // Response payload is broadcast; only the routed valid qualifies it.
  always_comb begin
    for (int unsigned p = 0; p < PORT_CNT; p++) begin
      cpu_resp[p] = l2_resp;
    end
  end

  // L2 request slot, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l2_req_valid    <= 1'b0;
      l2_req          <= '0;
      rr_ptr          <= '0;
      err_orphan_resp <= 1'b0;
    end else begin
      if (accept) begin
        l2_req       <= cpu_req[grant_idx];
        l2_req_valid <= 1'b1;
        rr_ptr       <= PORT_W'(orv64_arb_wrap_add(32'(grant_idx), 1, PORT_CNT));
      end else if (slot_free) begin
        l2_req_valid <= 1'b0;
      end
      if (orphan_seen) begin
        err_orphan_resp <= 1'b1;
      end
    end
  end

  orv64_arb_order_fifo #(
    .DEPTH  (OUTSTANDING),
    .DATA_W (PORT_W),
    .CNT_W  (CNT_W)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (grant_idx),
    .pop       (resp_pop),
    .head      (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight_cnt)
  );

endmodule

// File: tb/tb_orv64_l2_port_arb.sv
// Bench for orv64_l2_port_arb: port/L2 agents, queue-based reference model, directed scenarios.
module tb_orv64_l2_port_arb;
  import orv64_typedef_pkg::*;

  localparam int unsigned PORT_CNT    = 8;
  localparam int unsigned OUTSTANDING = 4;
  localparam int unsigned CNT_W       = $clog2(OUTSTANDING + 1);
  localparam int          L2_DEPTH    = 64;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [PORT_CNT-1:0]      cpu_req_valid;
  logic [PORT_CNT-1:0]      cpu_req_ready;
  cpu_req_t [PORT_CNT-1:0]  cpu_req;
  logic [PORT_CNT-1:0]      cpu_resp_valid;
  logic [PORT_CNT-1:0]      cpu_resp_ready;
  cpu_resp_t [PORT_CNT-1:0] cpu_resp;
  logic                     l2_req_valid;
  logic                     l2_req_ready;
  cpu_req_t                 l2_req;
  logic                     l2_resp_valid;
  logic                     l2_resp_ready;
  cpu_resp_t                l2_resp;
  logic [CNT_W-1:0]         inflight_cnt;
  logic                     err_orphan_resp;

  orv64_l2_port_arb #(
    .PORT_CNT    (PORT_CNT),
    .OUTSTANDING (OUTSTANDING)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req         (cpu_req),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_ready  (cpu_resp_ready),
    .cpu_resp        (cpu_resp),
    .l2_req_valid    (l2_req_valid),
    .l2_req_ready    (l2_req_ready),
    .l2_req          (l2_req),
    .l2_resp_valid   (l2_resp_valid),
    .l2_resp_ready   (l2_resp_ready),
    .l2_resp         (l2_resp),
    .inflight_cnt    (inflight_cnt),
    .err_orphan_resp (err_orphan_resp)
  );

  always #5 clk = ~clk;

  // Knobs owned by the main sequence.
  int   req_tot [PORT_CNT];
  int   resp_allow;
  logic orphan_force;

  // State owned by the port / L2 agents.
  int       gnt [PORT_CNT];
  int       l2_wr;
  int       l2_rd;
  int       resp_done;
  cpu_req_t l2_mem [L2_DEPTH];

  function automatic cpu_req_t mk_req(int p, int s);
    cpu_req_t r;
    r.addr  = 40'(p * 4096 + s * 8);
    r.we    = s[0];
    r.wdata = {32'(p), 32'(s)};
    r.mask  = 8'hFF;
    return r;
  endfunction

  function automatic cpu_resp_t mk_resp(cpu_req_t r);
    cpu_resp_t x;
    x.rdata = {24'hC0FFEE, r.addr} ^ r.wdata;
    x.err   = 1'b0;
    return x;
  endfunction

  // Each port presents its next request while it still has requests owed.
  always_comb begin
    for (int p = 0; p < PORT_CNT; p++) begin
      cpu_req_valid[p] = (req_tot[p] > gnt[p]);
      cpu_req[p]       = mk_req(p, gnt[p]);
    end
    l2_resp_valid = orphan_force || ((l2_rd != l2_wr) && (resp_done < resp_allow));
    l2_resp       = (l2_rd != l2_wr) ? mk_resp(l2_mem[l2_rd]) : '0;
  end

  // Port grant counters and the in-order perfect L2 model.
  always @(posedge clk) begin
    if (!rst_n) begin
      l2_rd <= l2_wr;
    end else begin
      for (int p = 0; p < PORT_CNT; p++) begin
        if (cpu_req_valid[p] && cpu_req_ready[p]) gnt[p] <= gnt[p] + 1;
      end
      if (l2_req_valid && l2_req_ready) begin
        l2_mem[l2_wr] <= l2_req;
        l2_wr         <= (l2_wr + 1) % L2_DEPTH;
      end
      if (l2_resp_valid && l2_resp_ready && (l2_rd != l2_wr)) begin
        l2_rd     <= (l2_rd + 1) % L2_DEPTH;
        resp_done <= resp_done + 1;
      end
    end
  end

  // Reference model state.
  logic     m_live = 1'b0;
  logic     m_slot_v;
  cpu_req_t m_slot;
  int       m_rr;
  int       m_q[$];
  logic     m_err;

  int n_tests = 0;
  int n_fail  = 0;
  int grant_log[$];
  bit log_en = 1'b0;
  int exp_order[6] = '{0, 3, 7, 0, 3, 7};

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model across the edge.
  task automatic model_step();
    logic [PORT_CNT-1:0] exp_rdy;
    logic [PORT_CNT-1:0] exp_rv;
    logic                exp_l2rr;
    logic                slot_free;
    logic                acc;
    logic                bad;
    int                  g;
    int                  head;
    if (!rst_n) begin
      chk("rst_cpu_req_ready", 128'(cpu_req_ready), 128'(0));
      chk("rst_cpu_resp_valid", 128'(cpu_resp_valid), 128'(0));
      m_live   = 1'b1;
      m_slot_v = 1'b0;
      m_slot   = '0;
      m_rr     = 0;
      m_q.delete();
      m_err    = 1'b0;
      return;
    end
    if (!m_live) return;
    chk("l2_req_valid", 128'(l2_req_valid), 128'(m_slot_v));
    if (m_slot_v) chk("l2_req", 128'(l2_req), 128'(m_slot));
    chk("inflight_cnt", 128'(inflight_cnt), 128'(m_q.size()));
    chk("err_orphan_resp", 128'(err_orphan_resp), 128'(m_err));
    slot_free = !m_slot_v || l2_req_ready;
    g = -1;
    for (int k = 0; k < PORT_CNT; k++) begin
      if (g < 0 && cpu_req_valid[(m_rr + k) % PORT_CNT]) g = (m_rr + k) % PORT_CNT;
    end
    acc = slot_free && (m_q.size() < OUTSTANDING) && (g >= 0);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    chk("cpu_req_ready", 128'(cpu_req_ready), 128'(exp_rdy));
    exp_rv   = '0;
    exp_l2rr = 1'b1;
    head     = 0;
    if (m_q.size() > 0) begin
      head         = m_q[0];
      exp_rv[head] = l2_resp_valid;
      exp_l2rr     = cpu_resp_ready[head];
    end
    chk("cpu_resp_valid", 128'(cpu_resp_valid), 128'(exp_rv));
    chk("l2_resp_ready", 128'(l2_resp_ready), 128'(exp_l2rr));
    bad = 1'b0;
    for (int p = 0; p < PORT_CNT; p++) begin
      if (cpu_resp[p] !== l2_resp) bad = 1'b1;
    end
    chk("cpu_resp_bcast", 128'(bad), 128'(0));
    if (acc && log_en) grant_log.push_back(g);
    if (l2_resp_valid) begin
      if (m_q.size() > 0) begin
        if (cpu_resp_ready[head]) void'(m_q.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    if (acc) begin
      m_slot   = cpu_req[g];
      m_slot_v = 1'b1;
      m_q.push_back(g);
      m_rr     = (g + 1) % PORT_CNT;
    end else if (slot_free) begin
      m_slot_v = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(int n);
    repeat (n) cyc();
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    #1;
    while ((inflight_cnt != '0 || l2_req_valid) && n < budget) begin
      cyc();
      #1;
      n++;
    end
    chk(name, 128'(inflight_cnt), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b4, b2, base_wr, base_done, cnt0, cnt3, cnt7;
    rst_n          = 1'b0;
    l2_req_ready   = 1'b1;
    cpu_resp_ready = '1;
    resp_allow     = 0;
    orphan_force   = 1'b0;

    // Reset state.
    cycles(2);
    rst_n = 1'b1;
    #1;
    chk("reset_l2_req_valid", 128'(l2_req_valid), 128'(0));
    chk("reset_inflight", 128'(inflight_cnt), 128'(0));
    chk("reset_err", 128'(err_orphan_resp), 128'(0));
    chk("reset_req_ready", 128'(cpu_req_ready), 128'(0));

    // Single port, four back-to-back requests, responses held then released.
    base_wr   = l2_wr;
    base_done = resp_done;
    b0        = gnt[0];
    req_tot[0] = req_tot[0] + 4;
    cycles(5);
    #1;
    chk("single_inflight_peak", 128'(inflight_cnt), 128'(4));
    chk("single_slot_cleared", 128'(l2_req_valid), 128'(0));
    chk("single_first_payload", 128'(l2_mem[base_wr]), 128'(mk_req(0, b0)));
    chk("single_last_payload", 128'(l2_mem[(base_wr + 3) % L2_DEPTH]), 128'(mk_req(0, b0 + 3)));
    resp_allow = resp_done + 4;
    wait_idle("single_drain", 30);
    chk("single_resp_count", 128'(resp_done - base_done), 128'(4));

    // Round-robin fairness from rr_ptr=0.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    resp_allow = resp_done + 1000;
    grant_log.delete();
    log_en = 1'b1;
    req_tot[0] = gnt[0] + 10;
    req_tot[3] = gnt[3] + 10;
    req_tot[7] = gnt[7] + 10;
    for (int n = 0; n < 100 && grant_log.size() < 30; n++) cyc();
    log_en = 1'b0;
    chk("rr_grant_total", 128'(grant_log.size()), 128'(30));
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("rr_grant_order", 128'(grant_log[i]), 128'(exp_order[i]));
    end
    cnt0 = 0; cnt3 = 0; cnt7 = 0;
    foreach (grant_log[i]) begin
      if (grant_log[i] == 0) cnt0++;
      if (grant_log[i] == 3) cnt3++;
      if (grant_log[i] == 7) cnt7++;
    end
    chk("rr_port0_share", 128'(cnt0), 128'(10));
    chk("rr_port3_share", 128'(cnt3), 128'(10));
    chk("rr_port7_share", 128'(cnt7), 128'(10));
    wait_idle("rr_drain", 30);

    // Credit limit: six pending, L2 silent.
    resp_allow = resp_done;
    b1 = gnt[1];
    b4 = gnt[4];
    req_tot[1] = gnt[1] + 3;
    req_tot[4] = gnt[4] + 3;
    cycles(8);
    #1;
    chk("credit_inflight", 128'(inflight_cnt), 128'(4));
    chk("credit_accepted", 128'((gnt[1] - b1) + (gnt[4] - b4)), 128'(4));
    chk("credit_no_ready", 128'(cpu_req_ready), 128'(0));
    resp_allow = resp_done + 1;
    #1;
    chk("credit_resp_valid", 128'(l2_resp_valid), 128'(1));
    chk("credit_no_bypass", 128'(cpu_req_ready), 128'(0));
    cyc();
    #1;
    chk("credit_after_pop_cnt", 128'(inflight_cnt), 128'(3));
    chk("credit_fifth_granted", 128'(|cpu_req_ready), 128'(1));
    resp_allow = resp_done + 1000;
    for (int n = 0; n < 40 && (gnt[1] + gnt[4] < b1 + b4 + 6); n++) cyc();
    wait_idle("credit_drain", 30);

    // Back-pressure on the L2 request slot.
    l2_req_ready = 1'b0;
    b2 = gnt[2];
    req_tot[2] = gnt[2] + 2;
    cyc();
    #1;
    chk("bp_captured", 128'(l2_req), 128'(mk_req(2, b2)));
    cycles(5);
    #1;
    chk("bp_hold_valid", 128'(l2_req_valid), 128'(1));
    chk("bp_hold_payload", 128'(l2_req), 128'(mk_req(2, b2)));
    chk("bp_no_ready", 128'(cpu_req_ready), 128'(0));
    l2_req_ready = 1'b1;
    cyc();
    #1;
    chk("bp_next_grant", 128'(l2_req), 128'(mk_req(2, b2 + 1)));
    wait_idle("bp_drain", 30);

    // Response stall on port 2 blocks the port-5 response behind it.
    resp_allow = resp_done;
    cpu_resp_ready[2] = 1'b0;
    req_tot[2] = gnt[2] + 1;
    cyc();
    req_tot[5] = gnt[5] + 1;
    cycles(3);
    resp_allow = resp_done + 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_l2_resp_ready", 128'(l2_resp_ready), 128'(0));
      chk("stall_resp_valid", 128'(cpu_resp_valid), 128'(8'b0000_0100));
      cyc();
    end
    cpu_resp_ready[2] = 1'b1;
    #1;
    chk("stall_release_valid", 128'(cpu_resp_valid), 128'(8'b0000_0100));
    chk("stall_release_ready", 128'(l2_resp_ready), 128'(1));
    cyc();
    #1;
    chk("stall_port5_valid", 128'(cpu_resp_valid), 128'(8'b0010_0000));
    cyc();
    resp_allow = resp_done + 1000;
    wait_idle("stall_drain", 30);

    // Orphan response with nothing outstanding.
    orphan_force = 1'b1;
    #1;
    chk("orphan_l2_resp_ready", 128'(l2_resp_ready), 128'(1));
    chk("orphan_no_resp_valid", 128'(cpu_resp_valid), 128'(0));
    cyc();
    orphan_force = 1'b0;
    #1;
    chk("orphan_sticky", 128'(err_orphan_resp), 128'(1));
    cycles(2);
    #1;
    chk("orphan_still_sticky", 128'(err_orphan_resp), 128'(1));

    // Reset with two transactions in flight.
    resp_allow = resp_done;
    req_tot[6] = gnt[6] + 2;
    cycles(4);
    #1;
    chk("midrst_inflight_before", 128'(inflight_cnt), 128'(2));
    rst_n = 1'b0;
    for (int p = 0; p < PORT_CNT; p++) req_tot[p] = gnt[p];
    cyc();
    rst_n = 1'b1;
    resp_allow = resp_done + 1000;
    #1;
    chk("midrst_inflight", 128'(inflight_cnt), 128'(0));
    chk("midrst_err", 128'(err_orphan_resp), 128'(0));
    chk("midrst_l2_req_valid", 128'(l2_req_valid), 128'(0));
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/orv64_l2_port_arb.md
Name: orv64_l2_port_arb

Overview:
- Round-robin arbiter between PORT_CNT cpu_req/cpu_resp ports (port 0 = ORV core, others = future masters) and the single request/response port of the L2 (perfect L2 model in bench, l2cache in silicon).
- Registers the winning request onto the L2 port.
- Tracks outstanding transactions in an in-order FIFO of port indices and routes each L2 response back to the port that issued it.

Parameters:
- PORT_CNT, 8, number of upstream ports (>=2)
- OUTSTANDING, 4, maximum in-flight L2 transactions (power of 2, >=2)
- PORT_W, $clog2(PORT_CNT), derived width of a port index
- CNT_W, $clog2(OUTSTANDING+1), derived width of the in-flight count

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- cpu_req_valid  in  [PORT_CNT]  per-port request valid
- cpu_req_ready  out  [PORT_CNT]  per-port request accepted
- cpu_req  in  cpu_req_t[PORT_CNT]  per-port request payload
- cpu_resp_valid  out  [PORT_CNT]  per-port response valid
- cpu_resp_ready  in  [PORT_CNT]  per-port response consumed
- cpu_resp  out  cpu_resp_t[PORT_CNT]  per-port response payload (broadcast copy of l2_resp)
- l2_req_valid  out  1  request to L2
- l2_req_ready  in  1  L2 accepts request
- l2_req  out  cpu_req_t  registered request payload
- l2_resp_valid  in  1  L2 response valid
- l2_resp_ready  out  1  response consumed
- l2_resp  in  cpu_resp_t  L2 response payload
- inflight_cnt  out  CNT_W  transactions accepted from upstream, response not yet returned
- err_orphan_resp  out  1  sticky: L2 response arrived with no outstanding transaction

Behaviour:
- Clock/reset: one clock domain. rst_n is synchronous, active-low. Reset takes priority over all other events.
- Reset values:
  - l2_req_valid=0, l2_req='0
  - rr_ptr=0, order FIFO empty, inflight_cnt=0, err_orphan_resp=0
  - all cpu_req_ready=0, all cpu_resp_valid=0
- Downstream contract (decided): L2 returns exactly one response per accepted request, in acceptance order.
- Slot free: slot_free = !l2_req_valid || l2_req_ready.
- Accept: accept = slot_free && (inflight_cnt < OUTSTANDING) && any cpu_req_valid. Both terms use start-of-cycle values; no same-cycle credit bypass from a popping response.
- Grant: first valid port at or after rr_ptr, scanning upward with wrap modulo PORT_CNT. cpu_req_ready[g]=accept for the granted port only; all other ports 0.
- On accept (same edge):
  - l2_req <= cpu_req[g]; l2_req_valid <= 1
  - push g into order FIFO
  - rr_ptr <= (g+1) mod PORT_CNT
- Latency: request accepted at edge N is visible on l2_req at cycle N+1.
- Back-pressure: when l2_req_valid && !l2_req_ready, l2_req and l2_req_valid hold stable and no new grant is issued.
- Slot clear: if slot_free && !accept, then l2_req_valid <= 0.
- Response routing (combinational):
  - head = FIFO head port
  - cpu_resp_valid[head] = l2_resp_valid; all other cpu_resp_valid = 0
  - l2_resp_ready = cpu_resp_ready[head]
  - pop the FIFO when l2_resp_valid && l2_resp_ready
- Orphan response: if l2_resp_valid arrives while the FIFO is empty, l2_resp_ready=1 (drop), err_orphan_resp <= 1 (sticky until reset), no cpu_resp_valid asserted.
- inflight_cnt: +1 on accept, -1 on pop. Simultaneous accept and pop leaves it unchanged. Never exceeds OUTSTANDING.
- Wrap-around: FIFO pointers are PORT_W-independent log2(OUTSTANDING) bits with an extra wrap bit for full/empty. rr_ptr wraps from PORT_CNT-1 to 0.
- Reset mid-operation: all in-flight state is discarded. The bench must also reset the L2 model.

Decomposition:
- Shared package orv64_typedef_pkg already provides cpu_req_t and cpu_resp_t; add to it:
  - orv64_arb_port_idx_t (PORT_W bits)
  - constant ORV64_L2_ARB_OUTSTANDING_DEFAULT=4
- One natural sub-module: orv64_arb_order_fifo, a synchronous FIFO of port indices with push, pop, full, empty and count. Arbiter logic stays in the top module.

Test Plan:
- Single port: port 0 issues 4 back-to-back requests, L2 always ready -> l2_req_valid high for cycles N+1..N+4 with payloads in order; 4 responses route only to cpu_resp_valid[0]; inflight_cnt peaks at 4 and returns to 0.
- Round-robin fairness: ports 0, 3 and 7 hold valid continuously, rr_ptr=0 -> grant order 0,3,7,0,3,7; no port starved across 30 grants.
- Credit limit: OUTSTANDING=4, L2 never responds, 6 requests pending -> exactly 4 accepted, cpu_req_ready stays 0 afterwards, inflight_cnt=4; one response returned -> the 5th request is accepted the following cycle, not the same cycle.
- Back-pressure: l2_req_ready=0 for 5 cycles with l2_req_valid=1 -> l2_req stable, no cpu_req_ready asserted; ready rises -> transfer completes and the next grant follows.
- Response routing/stall: requests from ports 2 then 5; cpu_resp_ready[2]=0 for 3 cycles -> l2_resp_ready=0 and the port-5 response is not delivered until port 2 consumes its response.
- Orphan response and reset: l2_resp_valid pulse with FIFO empty -> err_orphan_resp=1, no cpu_resp_valid, l2_resp_ready=1. Then rst_n=0 for 1 cycle with 2 in flight -> inflight_cnt=0, err_orphan_resp=0, l2_req_valid=0 on the next cycle.
